// File: rtl/apple1_pia_io.sv
// Apple-1 PIA-style keyboard/display port pair: 4-byte register window,
// keyboard FIFO with sticky overflow, and a valid/ready display handshake.
// Ports: clk7/rst_n, CPU bus (cpu_clken, addr, we, din, cs, dout),
// keyboard (kbd_strobe, kbd_data), display (dsp_valid, dsp_data, dsp_ready), irq_n.
module apple1_pia_io #(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          KBD_DEPTH = 8,
  parameter bit          IRQ_EN    = 1'b0
) (
  input  logic        clk7,
  input  logic        rst_n,
  input  logic        cpu_clken,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic        cs,
  output logic [7:0]  dout,
  input  logic        kbd_strobe,
  input  logic [7:0]  kbd_data,
  output logic        dsp_valid,
  output logic [6:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        irq_n
);

  localparam int AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(KBD_DEPTH);

  typedef enum logic {IDLE, PEND} dsp_st_t;

  logic [6:0]    fifo [KBD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  dsp_st_t       state;
  logic [6:0]    last_char;

  logic          bus_rd;
  logic          bus_wr;
  logic [1:0]    reg_sel;
  logic          nonempty;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;
  logic          busy;
  logic [7:0]    rd_mux;
  logic          unused_kbd7;

  assign unused_kbd7 = kbd_data[7];

  assign cs       = (addr[15:2] == BASE_ADDR[15:2]);
  assign bus_rd   = cpu_clken & cs & ~we;
  assign bus_wr   = cpu_clken & cs & we;
  assign reg_sel  = addr[1:0];
  assign nonempty = (count != '0);
  assign full     = (count == FULL);
  assign busy     = (state == PEND);

  // Pop only a real entry; an empty read returns 8'h80 and leaves the
  // FIFO alone even if a char is being pushed on the same edge.
  assign pop     = bus_rd & (reg_sel == 2'd0) & nonempty;
  // A pop on the same edge frees the slot the push needs.
  assign push    = kbd_strobe & (~full | pop);
  assign ovf_set = kbd_strobe & full & ~pop;
  assign ovf_clr = bus_wr & (reg_sel == 2'd1) & din[6];

  always_comb begin
    rd_mux = 8'h00;
    unique case (reg_sel)
      2'd0: rd_mux = nonempty ? {1'b1, fifo[rd_ptr]} : 8'h80;
      2'd1: rd_mux = {nonempty, overflow, 6'b0};
      2'd2: rd_mux = {busy, last_char};
      2'd3: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk7) begin
    if (push) fifo[wr_ptr] <= kbd_data[6:0];
  end

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dout     <= 8'h00;
      irq_n    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new overflow beats a simultaneous software clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (bus_rd) dout <= rd_mux;
      irq_n <= ~(IRQ_EN & nonempty);
    end
  end

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dsp_valid <= 1'b0;
      dsp_data  <= 7'h00;
      last_char <= 7'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus_wr && reg_sel == 2'd2) begin
            state     <= PEND;
            dsp_valid <= 1'b1;
            dsp_data  <= din[6:0];
            last_char <= din[6:0];
          end
        end
        PEND: begin
          if (dsp_valid && dsp_ready) begin
            state     <= IDLE;
            dsp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
